// File: rtl/image_tile_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// image_tile_dispatcher_pkg
// Shared definitions for the tile dispatcher: Avalon register addresses,
// CONTROL/STATUS bit positions, the scheduler FSM state type and a helper
// that sizes core-index fields.
// ---------------------------------------------------------------------------
package image_tile_dispatcher_pkg;

   // Avalon register map (word addresses)
   localparam logic [2:0] ADDR_STATUS     = 3'd0;
   localparam logic [2:0] ADDR_CONTROL    = 3'd1;
   localparam logic [2:0] ADDR_TILE_TOTAL = 3'd2;
   localparam logic [2:0] ADDR_ISSUED     = 3'd3;
   localparam logic [2:0] ADDR_COMPLETED  = 3'd4;
   localparam logic [2:0] ADDR_LAST_GRANT = 3'd5;

   // STATUS bits
   localparam int STATUS_DONE_BIT = 0;
   localparam int STATUS_BUSY_BIT = 1;

   // CONTROL bits
   localparam int CTRL_IRQ_EN_BIT = 0;
   localparam int CTRL_START_BIT  = 2;
   localparam int CTRL_ABORT_BIT  = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   // Width of a binary core index; never narrower than one bit.
   function automatic int idx_width(input int num_procs);
      return (num_procs > 2) ? $clog2(num_procs) : 1;
   endfunction

endpackage

// File: rtl/image_tile_dispatcher_if.sv
// ---------------------------------------------------------------------------
// image_tile_dispatcher_if
// Bundles the host Avalon-MM slave port, the interrupt and the per-core
// req/gnt/done handshake of the tile dispatcher.
//   master : host bus + processing cores (drive address/strobes/req/done)
//   slave  : the dispatcher (drives readdata, irq, gnt, gnt_tile)
// ---------------------------------------------------------------------------
interface image_tile_dispatcher_if #(
   parameter int NUM_PROCS = 2,
   parameter int TILE_W    = 13
) ();
   logic [2:0]           address;
   logic                 chipselect;
   logic                 write_n;
   logic [15:0]          writedata;
   logic [15:0]          readdata;
   logic                 irq;
   logic [NUM_PROCS-1:0] req;
   logic [NUM_PROCS-1:0] gnt;
   logic [TILE_W-1:0]    gnt_tile;
   logic [NUM_PROCS-1:0] done;

   modport master (
      output address, chipselect, write_n, writedata, req, done,
      input  readdata, irq, gnt, gnt_tile
   );

   modport slave (
      input  address, chipselect, write_n, writedata, req, done,
      output readdata, irq, gnt, gnt_tile
   );
endinterface

// File: rtl/image_tile_dispatcher_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search begins at the core after
// `ptr` (wrapping at NUM_PROCS) and returns the first eligible requester.
//   req_eligible : requests already masked by the caller
//   ptr          : index of the most recent winner
//   winner_onehot: one-hot winner, all zero when nothing is eligible
//   winner_idx   : binary index of the winner (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
   import image_tile_dispatcher_pkg::*;
#(
   parameter int NUM_PROCS = 2,
   parameter int IDX_W     = idx_width(NUM_PROCS)
) (
   input  logic [NUM_PROCS-1:0] req_eligible,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PROCS-1:0] winner_onehot,
   output logic [IDX_W-1:0]     winner_idx
);

   logic [IDX_W-1:0] start_idx;

   assign start_idx = (ptr == IDX_W'(NUM_PROCS - 1)) ? '0 : ptr + IDX_W'(1);

   always_comb begin
      int               cand;
      logic             found;
      logic [IDX_W-1:0] cand_idx;
      winner_onehot = '0;
      winner_idx    = '0;
      found         = 1'b0;
      cand          = 0;
      cand_idx      = '0;
      for (int k = 0; k < NUM_PROCS; k++) begin
         // start_idx + k never exceeds 2*NUM_PROCS-2, so one wrap suffices
         cand = int'(start_idx) + k;
         if (cand >= NUM_PROCS) begin
            cand = cand - NUM_PROCS;
         end
         cand_idx = IDX_W'(cand);
         if (!found && req_eligible[cand_idx]) begin
            found                   = 1'b1;
            winner_onehot[cand_idx] = 1'b1;
            winner_idx              = cand_idx;
         end
      end
   end

endmodule

// File: rtl/image_tile_dispatcher.sv
// ---------------------------------------------------------------------------
// image_tile_dispatcher
// Splits an image job into TILE_TOTAL numbered tiles and hands them to
// NUM_PROCS cores with a round-robin req/gnt handshake, counts completions
// and raises irq once every issued tile has been reported done.
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : Avalon register port, irq, req/gnt/gnt_tile/done (slave side)
// ---------------------------------------------------------------------------
module image_tile_dispatcher
   import image_tile_dispatcher_pkg::*;
#(
   parameter int NUM_PROCS = 2,
   parameter int TILE_W    = 13
) (
   input  logic                    clk,
   input  logic                    reset,
   image_tile_dispatcher_if.slave  bus
);

   localparam int IDX_W = idx_width(NUM_PROCS);

   state_t               state_reg, state_next;
   logic [TILE_W-1:0]    tile_total_reg;
   logic [TILE_W-1:0]    issued_reg, issued_next;
   logic [TILE_W-1:0]    completed_reg, completed_next;
   logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
   logic                 irq_en_reg;
   logic                 done_flag_reg, done_flag_next;
   logic [NUM_PROCS-1:0] gnt_reg, gnt_next;
   logic [TILE_W-1:0]    gnt_tile_reg, gnt_tile_next;
   logic [15:0]          readdata_reg;
   logic [15:0]          read_mux;

   logic                 wr_en, rd_en;
   logic                 ctrl_wr, status_wr, total_wr;
   logic                 start_strobe, abort_strobe;
   logic                 busy;
   logic [NUM_PROCS-1:0] req_eligible, win_onehot;
   logic [IDX_W-1:0]     win_idx;
   logic [TILE_W-1:0]    done_cnt, outstanding, credit;

   assign busy         = (state_reg != ST_IDLE);
   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign rd_en        = bus.chipselect &  bus.write_n;
   assign status_wr    = wr_en && (bus.address == ADDR_STATUS);
   assign ctrl_wr      = wr_en && (bus.address == ADDR_CONTROL);
   assign total_wr     = wr_en && (bus.address == ADDR_TILE_TOTAL) && !busy;
   assign start_strobe = ctrl_wr & bus.writedata[CTRL_START_BIT];
   assign abort_strobe = ctrl_wr & bus.writedata[CTRL_ABORT_BIT];

   // A core granted last cycle still shows req (it drops it one cycle after
   // seeing gnt), so it is masked for one cycle to avoid a double grant.
   assign req_eligible = bus.req & ~gnt_reg;

   rr_arbiter #(
      .NUM_PROCS (NUM_PROCS),
      .IDX_W     (IDX_W)
   ) u_rr_arbiter (
      .req_eligible  (req_eligible),
      .ptr           (last_grant_reg),
      .winner_onehot (win_onehot),
      .winner_idx    (win_idx)
   );

   // Completion credit: number of done pulses, clipped to tiles in flight so
   // COMPLETED can never pass ISSUED.
   always_comb begin
      done_cnt = '0;
      for (int k = 0; k < NUM_PROCS; k++) begin
         done_cnt = done_cnt + TILE_W'(bus.done[k]);
      end
      outstanding = issued_reg - completed_reg;
      credit      = (done_cnt < outstanding) ? done_cnt : outstanding;
   end

   always_comb begin
      state_next      = state_reg;
      issued_next     = issued_reg;
      completed_next  = completed_reg;
      last_grant_next = last_grant_reg;
      gnt_next        = '0;
      gnt_tile_next   = '0;
      done_flag_next  = status_wr ? 1'b0 : done_flag_reg;

      if (busy) begin
         completed_next = completed_reg + credit;
      end

      case (state_reg)
         ST_IDLE: begin
            if (start_strobe) begin
               if (tile_total_reg != '0) begin
                  state_next     = ST_DISPATCH;
                  issued_next    = '0;
                  completed_next = '0;
               end else begin
                  done_flag_next = 1'b1;
               end
            end
         end
         ST_DISPATCH: begin
            if ((win_onehot != '0) && (issued_reg < tile_total_reg)) begin
               gnt_next        = win_onehot;
               gnt_tile_next   = issued_reg;
               issued_next     = issued_reg + TILE_W'(1);
               last_grant_next = win_idx;
               if (issued_reg + TILE_W'(1) == tile_total_reg) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The set of done_flag takes priority over a same-cycle STATUS write
            if (completed_next == tile_total_reg) begin
               state_next     = ST_IDLE;
               done_flag_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Abort overrides everything above, including a simultaneous start;
      // counters freeze so the host can read how far the job got.
      if (abort_strobe) begin
         state_next      = ST_IDLE;
         issued_next     = issued_reg;
         completed_next  = completed_reg;
         last_grant_next = last_grant_reg;
         gnt_next        = '0;
         gnt_tile_next   = '0;
         done_flag_next  = status_wr ? 1'b0 : done_flag_reg;
      end
   end

   always_comb begin
      read_mux = '0;
      case (bus.address)
         ADDR_STATUS: begin
            read_mux[STATUS_DONE_BIT] = done_flag_reg;
            read_mux[STATUS_BUSY_BIT] = busy;
         end
         ADDR_CONTROL:    read_mux[CTRL_IRQ_EN_BIT] = irq_en_reg;
         ADDR_TILE_TOTAL: read_mux[TILE_W-1:0]      = tile_total_reg;
         ADDR_ISSUED:     read_mux[TILE_W-1:0]      = issued_reg;
         ADDR_COMPLETED:  read_mux[TILE_W-1:0]      = completed_reg;
         ADDR_LAST_GRANT: read_mux[IDX_W-1:0]       = last_grant_reg;
         default:         read_mux                  = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         tile_total_reg <= '0;
         issued_reg     <= '0;
         completed_reg  <= '0;
         last_grant_reg <= '0;
         irq_en_reg     <= 1'b0;
         done_flag_reg  <= 1'b0;
         gnt_reg        <= '0;
         gnt_tile_reg   <= '0;
         readdata_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         issued_reg     <= issued_next;
         completed_reg  <= completed_next;
         last_grant_reg <= last_grant_next;
         done_flag_reg  <= done_flag_next;
         gnt_reg        <= gnt_next;
         gnt_tile_reg   <= gnt_tile_next;
         if (ctrl_wr) begin
            irq_en_reg <= bus.writedata[CTRL_IRQ_EN_BIT];
         end
         if (total_wr) begin
            tile_total_reg <= bus.writedata[TILE_W-1:0];
         end
         if (rd_en) begin
            readdata_reg <= read_mux;
         end
      end
   end

   assign bus.readdata = readdata_reg;
   assign bus.gnt      = gnt_reg;
   assign bus.gnt_tile = gnt_tile_reg;
   assign bus.irq      = done_flag_reg & irq_en_reg;

   // Write-data bits above the tile-count field carry no meaning.
   generate
      if (TILE_W < 16) begin : g_wd_unused
         logic unused_writedata;
         assign unused_writedata = ^bus.writedata[15:TILE_W];
      end
   endgenerate

endmodule

// File: tb/tb_image_tile_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_image_tile_dispatcher
// Directed self-checking bench for image_tile_dispatcher (2 cores, 13-bit
// tile counters). A small core model drops req for one cycle after each
// grant; a monitor logs every grant with its cycle number.
// ---------------------------------------------------------------------------
module tb_image_tile_dispatcher;
   import image_tile_dispatcher_pkg::*;

   localparam int NP = 2;
   localparam int TW = 13;

   logic clk;
   logic reset;
   int   n_asserts;
   int   n_fail;
   int   cyc_cnt;

   logic [NP-1:0] want;
   logic [NP-1:0] core_hold;
   logic          drop_en;

   logic [NP-1:0] glog_gnt[$];
   int            glog_tile[$];
   int            glog_cyc[$];

   image_tile_dispatcher_if #(.NUM_PROCS(NP), .TILE_W(TW)) bus ();

   image_tile_dispatcher #(.NUM_PROCS(NP), .TILE_W(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: a core that saw gnt drops req for the following cycle.
   always @(posedge clk) begin
      if (reset) core_hold <= '0;
      else       core_hold <= bus.gnt;
   end
   assign bus.req = want & ~(core_hold & {NP{drop_en}});

   // Grant monitor
   always @(negedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      if (bus.gnt != '0) begin
         glog_gnt.push_back(bus.gnt);
         glog_tile.push_back(int'(bus.gnt_tile));
         glog_cyc.push_back(cyc_cnt);
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus tasks are called at a negedge; each returns at the next negedge.
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      @(negedge clk);
      bus.chipselect = 1'b0;
      check(tag, {16'h0, bus.readdata}, {16'h0, exp});
   endtask

   task automatic done_pulse(input logic [NP-1:0] v);
      bus.done = v;
      @(negedge clk);
      bus.done = '0;
   endtask

   task automatic wait_grants(input int n, input string tag);
      int k;
      k = 0;
      while (glog_gnt.size() < n && k < 60) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, (glog_gnt.size() >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic clear_log();
      glog_gnt.delete();
      glog_tile.delete();
      glog_cyc.delete();
   endtask

   initial begin
      n_asserts      = 0;
      n_fail         = 0;
      cyc_cnt        = 0;
      reset          = 1'b1;
      want           = '0;
      drop_en        = 1'b1;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      bus.done       = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // ---------------- reset state ----------------
      check("rst_readdata", {16'h0, bus.readdata}, 32'h0);
      check("rst_irq", {31'h0, bus.irq}, 32'h0);
      check("rst_gnt", {30'h0, bus.gnt}, 32'h0);
      check("rst_gnt_tile", {19'h0, bus.gnt_tile}, 32'h0);
      rd_check("rst_status", ADDR_STATUS, 16'h0);
      rd_check("rst_total", ADDR_TILE_TOTAL, 16'h0);

      // ---------------- basic job ----------------
      wr(ADDR_CONTROL, 16'h0001);
      wr(ADDR_TILE_TOTAL, 16'd4);
      rd_check("basic_total", ADDR_TILE_TOTAL, 16'd4);
      rd_check("basic_ctrl", ADDR_CONTROL, 16'h0001);
      clear_log();
      want = 2'b01;                   // core0 asks first, core1 a cycle later
      wr(ADDR_CONTROL, 16'h0005);
      @(negedge clk);
      want = 2'b11;
      wait_grants(4, "basic_wait");
      want = 2'b00;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("basic_gnt%0d", i), {30'h0, glog_gnt[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("basic_tile%0d", i), glog_tile[i], i);
      end
      rd_check("basic_issued", ADDR_ISSUED, 16'd4);
      rd_check("basic_drain", ADDR_STATUS, 16'h2);
      done_pulse(2'b01);
      done_pulse(2'b10);
      done_pulse(2'b01);
      check("basic_irq_early", {31'h0, bus.irq}, 32'h0);
      rd_check("basic_comp3", ADDR_COMPLETED, 16'd3);
      done_pulse(2'b10);
      check("basic_irq", {31'h0, bus.irq}, 32'h1);
      rd_check("basic_done", ADDR_STATUS, 16'h1);
      rd_check("basic_comp4", ADDR_COMPLETED, 16'd4);
      wr(ADDR_STATUS, 16'h0);
      check("basic_irq_clr", {31'h0, bus.irq}, 32'h0);

      // ---------------- zero total ----------------
      clear_log();
      wr(ADDR_TILE_TOTAL, 16'd0);
      want = 2'b11;
      wr(ADDR_CONTROL, 16'h0005);
      check("zero_irq", {31'h0, bus.irq}, 32'h1);
      rd_check("zero_status", ADDR_STATUS, 16'h1);
      repeat (4) @(negedge clk);
      check("zero_no_gnt", glog_gnt.size(), 32'd0);
      want = 2'b00;
      wr(ADDR_STATUS, 16'h0);

      // ---------------- simultaneous completions ----------------
      clear_log();
      wr(ADDR_TILE_TOTAL, 16'd3);
      want = 2'b11;
      wr(ADDR_CONTROL, 16'h0005);
      wait_grants(2, "sim_wait");
      want = 2'b00;
      rd_check("sim_issued", ADDR_ISSUED, 16'd2);
      done_pulse(2'b11);
      rd_check("sim_comp2", ADDR_COMPLETED, 16'd2);
      done_pulse(2'b01);
      rd_check("sim_comp_excess", ADDR_COMPLETED, 16'd2);
      rd_check("sim_busy", ADDR_STATUS, 16'h2);
      wr(ADDR_CONTROL, 16'h0009);
      rd_check("sim_abort_idle", ADDR_STATUS, 16'h0);

      // ---------------- abort mid-dispatch ----------------
      clear_log();
      wr(ADDR_TILE_TOTAL, 16'd10);
      want = 2'b11;
      wr(ADDR_CONTROL, 16'h0005);
      wait_grants(3, "abort_wait");
      wr(ADDR_CONTROL, 16'h0009);
      check("abort_gnt0", {30'h0, bus.gnt}, 32'h0);
      rd_check("abort_status", ADDR_STATUS, 16'h0);
      repeat (3) @(negedge clk);
      check("abort_no_more_gnt", glog_gnt.size(), 32'd3);
      rd_check("abort_issued", ADDR_ISSUED, 16'd3);
      want = 2'b00;
      wr(ADDR_TILE_TOTAL, 16'd7);
      rd_check("abort_total_wr", ADDR_TILE_TOTAL, 16'd7);

      // ---------------- single requester ----------------
      clear_log();
      drop_en = 1'b0;                 // core1 holds req continuously
      want    = 2'b10;
      wr(ADDR_TILE_TOTAL, 16'd4);
      wr(ADDR_CONTROL, 16'h0005);
      wr(ADDR_TILE_TOTAL, 16'd2);     // busy: must be ignored
      rd_check("single_total_kept", ADDR_TILE_TOTAL, 16'd4);
      wait_grants(4, "single_wait");
      want = 2'b00;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("single_space%0d", i), glog_cyc[i+1] - glog_cyc[i], 32'd2);
      end
      check("single_core", {30'h0, glog_gnt[3]}, 32'h2);
      rd_check("single_last", ADDR_LAST_GRANT, 16'd1);
      rd_check("single_drain", ADDR_STATUS, 16'h2);
      drop_en = 1'b1;

      // ---------------- reset mid-job ----------------
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_irq", {31'h0, bus.irq}, 32'h0);
      check("mrst_gnt", {30'h0, bus.gnt}, 32'h0);
      for (int a = 0; a < 6; a++) begin
         rd_check($sformatf("mrst_reg%0d", a), 3'(a), 16'h0);
      end
      wr(ADDR_CONTROL, 16'h0001);
      wr(ADDR_TILE_TOTAL, 16'd2);
      clear_log();
      want = 2'b11;
      wr(ADDR_CONTROL, 16'h0005);
      wait_grants(2, "post_wait");
      want = 2'b00;
      check("post_gnt0", {30'h0, glog_gnt[0]}, 32'h2);
      check("post_tile0", glog_tile[0], 32'd0);
      check("post_gnt1", {30'h0, glog_gnt[1]}, 32'h1);
      check("post_tile1", glog_tile[1], 32'd1);
      done_pulse(2'b11);
      check("post_irq", {31'h0, bus.irq}, 32'h1);
      rd_check("post_status", ADDR_STATUS, 16'h1);
      rd_check("post_comp", ADDR_COMPLETED, 16'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/image_tile_dispatcher.md
# image_tile_dispatcher

Avalon-MM-configured scheduler that splits an image job into TILE_TOTAL numbered tiles and hands them out to NUM_PROCS Nios processing cores via a round-robin req/gnt handshake. It counts completions and raises `irq` to the host core once every issued tile is reported done. It sits on the host core's peripheral bus alongside the interval timer, with the req/gnt/done lines routed to per-core PIO bridges.

## Interface
- `NUM_PROCS`, default 2: number of requesting cores (2..8).
- `TILE_W`, default 13: tile index / count width.

- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `address` in 3: Avalon register select.
- `chipselect` in 1: Avalon select.
- `write_n` in 1: Avalon write strobe, active-low.
- `writedata` in 16: Avalon write data.
- `readdata` out 16: registered read data.
- `irq` out 1: `done_flag & irq_en`.
- `req` in NUM_PROCS: level request for a tile, one bit per core.
- `gnt` out NUM_PROCS: one-cycle one-hot grant pulse.
- `gnt_tile` out TILE_W: tile index, valid only while `gnt` is nonzero.
- `done` in NUM_PROCS: one-cycle pulse per finished tile; several bits may pulse together.

## Operation
- Register map. Reads return 0 on unused bits and at addresses 6–7.
  - 0 STATUS: read `{busy, done_flag}` in bits [1:0]; any write clears `done_flag`.
  - 1 CONTROL: bit0 `irq_en` is read/write; bit2 `start` and bit3 `abort` are write-only strobes that read as 0.
  - 2 TILE_TOTAL: read/write, TILE_W bits; writes are ignored while `busy`.
  - 3 ISSUED: read-only.
  - 4 COMPLETED: read-only.
  - 5 LAST_GRANT: index of the last granted core, read-only.
- FSM states are IDLE, DISPATCH and DRAIN; `busy` = state ≠ IDLE.
- IDLE:
  - `start` with TILE_TOTAL > 0 → DISPATCH; ISSUED and COMPLETED clear to 0.
  - `start` with TILE_TOTAL = 0 → `done_flag` set; state stays IDLE.
  - `start` while busy is ignored.
- DISPATCH:
  - Each cycle with eligible `req` and ISSUED < TILE_TOTAL, grant the single round-robin winner.
  - Search order starts at `LAST_GRANT+1` mod NUM_PROCS.
  - On a grant: `gnt_tile` = ISSUED, then ISSUED increments.
  - When ISSUED reaches TILE_TOTAL → DRAIN.
- DRAIN: when COMPLETED = TILE_TOTAL → IDLE and set `done_flag`.
- Eligibility: a core granted in cycle t is masked in cycle t+1. Cores must drop `req` in the cycle after seeing `gnt`.
- Completion: while busy, COMPLETED += min(popcount(`done`), ISSUED − COMPLETED). Done pulses in IDLE, and any excess pulses, are ignored.
- `abort` (from any state) → IDLE. `gnt` is forced to 0 the next cycle, `done_flag` is unchanged, and ISSUED/COMPLETED hold for readback.
- `abort` and `start` written together: `abort` wins and the block ends in IDLE.
- A STATUS write in the same cycle as the completion that sets `done_flag`: the set wins.
- Arithmetic is unsigned TILE_W, with no wrap: ISSUED ≤ TILE_TOTAL and COMPLETED ≤ ISSUED always.

## Timing
- Reset values:
  - State IDLE; ISSUED, COMPLETED, TILE_TOTAL, LAST_GRANT all 0.
  - `irq_en` = 0, `done_flag` = 0.
  - `gnt` = 0, `gnt_tile` = 0, `readdata` = 0, `irq` = 0.
- Reset mid-job: same reset values on the next edge; in-flight grants are lost.
- Read latency is 1: `readdata` is valid the cycle after `chipselect`. No wait states.
- Writes take effect at the clock edge. A start written at edge t gives DISPATCH at t+1, and the earliest `gnt` comes at t+2.
- `req` sampled at edge t → `gnt`/`gnt_tile` registered and high during cycle t+1.
- Sustained throughput is one grant per cycle (with ≥2 cores requesting); a single core gets at most one grant every 2 cycles.
- The final `done` sampled at edge t → `done_flag`/`irq` high at t+1, and `busy` low at t+1.

## Structure
- Package `image_tile_dispatcher_pkg` holds:
  - register address constants 0–5;
  - CONTROL/STATUS bit positions;
  - the FSM state enum.
- Sub-module `rr_arbiter`, parameterised on NUM_PROCS:
  - inputs: eligible request vector and pointer;
  - outputs: one-hot winner and its binary index;
  - purely combinational.
- The top level holds the FSM, counters, registers and popcount.

## Test plan
- **Basic job.** NUM_PROCS=2, TILE_TOTAL=4, start; both `req` held, each core dropping and re-asserting `req` after its grant.
  - Grants alternate core0/1/0/1 with tiles 0,1,2,3.
  - ISSUED=4 and state DRAIN.
  - Four `done` pulses → `irq`=1 one cycle after the last.
  - A STATUS write clears `irq`.
- **Zero total.** TILE_TOTAL=0, start → `done_flag`=1 next cycle, no `gnt` ever.
- **Simultaneous completions.** TILE_TOTAL=3 with 2 tiles issued; `done`=2'b11 in one cycle → COMPLETED=2.
  - An extra pulse while ISSUED=COMPLETED leaves COMPLETED unchanged.
- **Abort mid-dispatch.** TILE_TOTAL=10, abort after 3 grants.
  - `busy`=0 next cycle, `gnt` stays 0, ISSUED reads 3, `done_flag`=0.
  - Writing TILE_TOTAL is then accepted.
- **Single requester.** Only core1 holds `req` continuously → grants every other cycle, LAST_GRANT reads 1.
  - A TILE_TOTAL write while busy is ignored.
- **Reset mid-job.** Reset during DRAIN → all registers read 0 and `irq`=0.
  - A subsequent start/job completes normally.
